// File: rtl/sys_ctrl_pkg.sv
// Shared types and default geometry for the systolic array sequencing controller.
package sys_ctrl_pkg;

  localparam int unsigned ROWS_DEF  = 32;
  localparam int unsigned COLS_DEF  = 32;
  localparam int unsigned MAX_K_DEF = 1024;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} ctrl_state_e;

endpackage

// File: rtl/systolic_seq_ctrl_phase_counter.sv
// Up-counter with synchronous clear, enable and a terminal-value flag; holds at terminal.
module phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == term);

  always_ff @(posedge clk) begin
    if (!rst)            count <= '0;
    else if (clr)        count <= '0;
    else if (en && !last) count <= count + W'(1);
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the systolic PE array: weight preload, k-beat streaming, pipeline drain.
module systolic_seq_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned MAX_K = MAX_K_DEF,
  localparam int unsigned KW   = $clog2(MAX_K + 1),
  localparam int unsigned RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          w_load_en,
  output logic [RW-1:0] w_row_idx,
  output logic          ps_en,
  output logic          drain_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned DW = $clog2(ROWS + COLS);

  ctrl_state_e   state;
  logic [KW-1:0] k_lat;
  logic [RW-1:0] row_cnt;
  logic [KW-1:0] k_cnt;
  logic [DW-1:0] d_cnt;
  logic          row_last, k_last, d_last;
  logic          fire, k_ok, start_ok;
  logic          row_en, k_clr, k_en, d_clr, d_en;
  logic          unused_cnts;

  // Handshake and phase decode; in_ready depends only on state.
  assign in_ready  = (state == LOAD_W) || (state == STREAM);
  assign fire      = in_valid && in_ready;
  assign w_load_en = fire && (state == LOAD_W);
  assign ps_en     = fire && (state == STREAM);
  assign drain_en  = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_row_idx = row_cnt;

  assign k_ok     = (k_len != '0) && (k_len <= KW'(MAX_K));
  assign start_ok = (state == IDLE) && start && !abort && k_ok;
  assign row_en   = w_load_en;
  assign k_clr    = row_en && row_last;
  assign k_en     = ps_en;
  assign d_clr    = k_en && k_last;
  assign d_en     = drain_en;

  assign unused_cnts = ^{k_cnt, d_cnt};

  phase_counter #(.W(RW)) u_row_cnt (
    .clk(clk), .rst(rst), .clr(start_ok), .en(row_en),
    .term(RW'(ROWS - 1)), .count(row_cnt), .last(row_last)
  );

  phase_counter #(.W(KW)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(k_clr), .en(k_en),
    .term(KW'(k_lat - KW'(1))), .count(k_cnt), .last(k_last)
  );

  phase_counter #(.W(DW)) u_drain_cnt (
    .clk(clk), .rst(rst), .clr(d_clr), .en(d_en),
    .term(DW'(ROWS + COLS - 2)), .count(d_cnt), .last(d_last)
  );

  // Phase FSM; abort outranks every transition except reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      k_lat <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if ((state != IDLE) && abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (k_ok) begin
                k_lat <= k_len;
                state <= LOAD_W;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD_W:  if (fire && row_last) state <= STREAM;
          STREAM:  if (fire && k_last)   state <= DRAIN;
          DRAIN:   if (d_last)           state <= DONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a 4x4 array geometry.
module tb_systolic_seq_ctrl;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned MAX_K = 1024;
  localparam int unsigned KW    = 11;
  localparam int unsigned RW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, w_load_en, ps_en, drain_en, busy, done, err;
  logic [RW-1:0] w_row_idx;

  int checks = 0;
  int errors = 0;

  systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .w_load_en(w_load_en),
    .w_row_idx(w_row_idx), .ps_en(ps_en), .drain_en(drain_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one tile from a start in the current cycle; checks each cycle against a beat model.
  task automatic run_tile(input int k, input bit stall, input bit poke, input int exp_done);
    int  fires = 0;
    int  dn = 0;
    int  dc = -1;
    int  extra = 0;
    bit  fe, edrain, edone, poked;
    poked = 1'b0;
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 0);
    chk("start_rdy", 32'(in_ready), 0);
    tick();
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      in_valid = stall ? c[0] : 1'b1;
      start = poke && !poked && (fires == int'(ROWS) + 2);
      if (start) poked = 1'b1;
      @(negedge clk);
      fe     = in_valid && (fires < int'(ROWS) + k);
      edrain = (fires == int'(ROWS) + k) && (dn < int'(ROWS + COLS - 1));
      edone  = (fires == int'(ROWS) + k) && (dn == int'(ROWS + COLS - 1));
      chk("in_ready", 32'(in_ready), 32'(fires < int'(ROWS) + k));
      chk("w_load_en", 32'(w_load_en), 32'(fe && fires < int'(ROWS)));
      chk("ps_en", 32'(ps_en), 32'(fe && fires >= int'(ROWS)));
      if (fires < int'(ROWS)) chk("w_row_idx", 32'(w_row_idx), 32'(fires));
      chk("drain_en", 32'(drain_en), 32'(edrain));
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 32'(edone));
      if (edrain) dn++;
      if (fe) fires++;
      if (done) begin
        dc = c;
        if (poke) start = 1'b1;
        break;
      end
      tick();
    end
    chk("done_cycle", 32'(dc), 32'(exp_done));
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    if (poke) begin
      repeat (20) begin
        @(negedge clk);
        if (busy || done) extra++;
      end
      chk("poke_ignored", 32'(extra), 0);
    end
    tick();
  endtask

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({in_ready, w_load_en, ps_en, drain_en, busy, done, err, w_row_idx}), 0);
    rst = 1'b1;

    run_tile(6, 1'b0, 1'b0, 18);
    run_tile(6, 1'b1, 1'b0, 27);

    // Illegal lengths: zero and one past the maximum.
    start = 1'b1; k_len = KW'(0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("err_k0", 32'(err), 1);
    chk("err_k0_idle", 32'({busy, in_ready}), 0);
    tick();
    @(negedge clk);
    chk("err_k0_pulse", 32'(err), 0);
    tick();
    start = 1'b1; k_len = KW'(MAX_K + 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("err_kmax", 32'(err), 1);
    chk("err_kmax_idle", 32'({busy, in_ready}), 0);
    tick();
    @(negedge clk);
    chk("err_kmax_pulse", 32'(err), 0);
    tick();

    // Abort together with start in IDLE drops the start silently.
    start = 1'b1; abort = 1'b1; k_len = KW'(3);
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start", 32'({busy, err}), 0);
    tick();

    // Abort on the third streaming beat.
    start = 1'b1; k_len = KW'(6); in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_ps", 32'(ps_en), 1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({busy, in_ready}), 0);
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 0);
    tick();
    run_tile(2, 1'b0, 1'b0, 14);

    // Reset mid-drain, then restart in the cycle reset is released.
    start = 1'b1; k_len = KW'(2); in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("mid_drain", 32'(drain_en), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_outs", 32'({in_ready, w_load_en, ps_en, drain_en, busy, done, err, w_row_idx}), 0);
    rst = 1'b1;
    run_tile(2, 1'b0, 1'b0, 14);

    run_tile(6, 1'b0, 1'b1, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Parametrised sequencing controller for the systolic PE array, and the next generation of the fixed 32-beat weight/partial-sum controller.
- Runs one tile per start pulse, in three phases:
  - weight preload: ROWS beats;
  - activation/partial-sum streaming: runtime k_len beats;
  - pipeline drain: ROWS+COLS-1 cycles.
- All data movement uses valid/ready handshakes, with done, error and abort handling.
- Sits between the tile scheduler (start/k_len) and the array input muxes (w_load_en, ps_en, drain_en).

Parameters:
- ROWS, 32, PE array rows = weight beats per tile.
- COLS, 32, PE array columns; sets the drain length.
- MAX_K, 1024, maximum streaming length in beats.
- KW, $clog2(MAX_K+1), width of k_len and of the stream counter (derived; do not override).
- RW, $clog2(ROWS), width of w_row_idx (derived).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  tile start request, sampled only in IDLE.
- k_len  in  KW  stream beats for this tile, latched with start.
- abort  in  1  abandon the current tile.
- in_valid  in  1  upstream data beat valid.
- in_ready  out  1  controller accepts a beat.
- w_load_en  out  1  shift weight row into the array this cycle.
- w_row_idx  out  RW  row index of the current weight beat.
- ps_en  out  1  advance activations/partial sums this cycle.
- drain_en  out  1  flush the array pipeline.
- busy  out  1  tile in progress.
- done  out  1  one-cycle tile-complete pulse.
- err  out  1  one-cycle illegal-request pulse.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: rst=0 at a rising edge forces IDLE and clears all counters and the latched k.
  - After that edge all outputs are 0.
  - Reset overrides start/abort in the same cycle.
  - Reset mid-tile drops the tile silently: no done, no err.
- State is registered. Outputs decode from state, counters and the handshake. fire = in_valid & in_ready.
- IDLE:
  - in_ready=0, busy=0.
  - start & 1<=k_len<=MAX_K: latch k_len, clear the row counter, go to LOAD_W next cycle.
  - start & (k_len==0 or k_len>MAX_K): err=1 for the next cycle only, stay in IDLE.
- LOAD_W:
  - in_ready=1, busy=1.
  - w_load_en=fire in the same cycle, combinational; w_row_idx = row counter.
  - Each fire increments the row counter. in_valid low stalls with no state change.
  - Fire with row counter == ROWS-1: go to STREAM and clear the k counter.
- STREAM:
  - in_ready=1, busy=1, ps_en=fire.
  - Each fire increments the k counter. Fire with k counter == latched k-1: go to DRAIN and clear the drain counter.
- DRAIN:
  - in_ready=0, busy=1, drain_en=1 for exactly ROWS+COLS-1 consecutive cycles, then go to DONE.
  - DRAIN does not depend on in_valid.
- DONE: done=1 and busy=1 for one cycle, then IDLE. A start arriving in DONE is ignored.
- First-tile latency: ROWS+k_len beats, plus ROWS+COLS-1 cycles, plus 1 cycle from the LOAD_W entry edge to done.
  - With no stalls, done asserts ROWS+k_len+ROWS+COLS cycles after the start cycle.
- Abort:
  - abort=1 in any non-IDLE state: go to IDLE next cycle, no done.
  - A fire in the abort cycle is still accepted, and its w_load_en/ps_en still asserts.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins, the start is dropped, no err.
- start while busy is ignored; there is no queuing.
- Counter widths:
  - Row counter is RW bits, k counter is KW bits, drain counter is $clog2(ROWS+COLS) bits.
  - No counter wraps within a legal tile.
- in_ready never depends on in_valid, so there is no combinational loop upstream.

Decomposition:
- Package sys_ctrl_pkg holds:
  - typedef enum logic [2:0] ctrl_state_e {IDLE, LOAD_W, STREAM, DRAIN, DONE};
  - default constants ROWS_DEF=32, COLS_DEF=32, MAX_K_DEF=1024.
- One sub-module, phase_counter: a parametrised width/terminal-value counter with clear, enable and a last flag. It is instantiated three times (row, k and drain counters).
- FSM and output decode stay in systolic_seq_ctrl.

Test Plan:
- ROWS=4, COLS=4. start with k_len=6, in_valid held at 1:
  - w_load_en on 4 cycles with w_row_idx 0,1,2,3, then ps_en on 6 cycles, then drain_en on 7 cycles;
  - done pulses exactly 18 cycles after the start cycle; busy is low again the cycle after.
- Same tile with in_valid toggling 1,0,1,0:
  - w_load_en and ps_en only on valid cycles, w_row_idx holds during gaps, total counts stay 4 and 6;
  - done timing is shifted by the number of stall cycles.
- start with k_len=0, then k_len=MAX_K+1:
  - err is a single-cycle pulse each time, state stays IDLE, busy=0, in_ready=0.
- abort asserted on the 3rd STREAM fire:
  - that ps_en is asserted, IDLE and in_ready=0 the next cycle, done never asserts;
  - a fresh start with k_len=2 then completes normally.
- rst=0 for one cycle mid-DRAIN:
  - all outputs 0 after that edge, no done;
  - start in the cycle rst returns high is accepted.
- start pulsed during STREAM and DONE: ignored, exactly one done per accepted start.
